mips_io_port: RTL and testbench

Memory-less I/O peripheral on the processor-facing side of the MIPS core's `data_in`/`data_out`/`interrupt` pins. It buffers words arriving from an external source in a small receive FIFO and presents the head word on `data_in`. It raises `interrupt` while a word is pending and retires the word on the processor's read acknowledge. It also captures `data_out` into a single transmit holding register on the processor's write strobe and hands the word to an external sink with a valid/ready handshake.

---
 rtl/mips_io_pkg.sv | 15 +
 rtl/mips_io_fifo.sv | 73 +++++++
 rtl/mips_io_port.sv | 100 ++++++++++
 tb/tb_mips_io_port.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_io_pkg.sv
// Shared types and constants for the MIPS I/O port: IRQ state encoding and error bit indices.
package mips_io_pkg;

    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        GAP  = 2'd2
    } irq_state_t;

    localparam int ERR_RD_EMPTY = 0;
    localparam int ERR_WR_BUSY  = 1;

endpackage

// File: rtl/mips_io_fifo.sv
// Receive FIFO: DEPTH x DATA_W circular buffer with a zero-when-empty head output.
// Latency: pushed word is visible on head_dat right after the push edge.
// Backpressure: full blocks push; pop while empty is ignored.
module mips_io_fifo
    import mips_io_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic              pop,
    output logic [DATA_W-1:0] head_dat,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = empty ? '0 : mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_dat;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: a zero count hides stale entries.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mips_io_port.sv
// Processor-side I/O port: RX FIFO with interrupt FSM, single-word TX holding register, sticky errors.
// Latency: RX word on data_in one edge after push, interrupt one edge later; TX valid one edge after strobe.
// Backpressure: ext_in_ready drops when the FIFO is full; a strobe while the TX register is busy is dropped.
module mips_io_port
    import mips_io_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RX_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ext_in_data,
    input  logic              ext_in_valid,
    output logic              ext_in_ready,
    output logic [DATA_W-1:0] data_in,
    output logic              interrupt,
    input  logic              cpu_rd_ack,
    input  logic [DATA_W-1:0] data_out,
    input  logic              cpu_wr_stb,
    output logic              tx_busy,
    output logic [DATA_W-1:0] ext_out_data,
    output logic              ext_out_valid,
    input  logic              ext_out_ready,
    output logic [1:0]        err_flags
);

    irq_state_t        state_q, state_d;
    logic [DATA_W-1:0] tx_reg_q, tx_reg_d;
    logic              tx_busy_q, tx_busy_d;
    logic [1:0]        err_q, err_d;
    logic              rx_full;
    logic              rx_empty;
    logic              rx_pop;

    // A pop is only honoured while the interrupt is up; PEND implies a non-empty FIFO.
    assign rx_pop = cpu_rd_ack && (state_q == PEND);

    mips_io_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RX_DEPTH)
    ) u_rx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (ext_in_valid),
        .wr_dat   (ext_in_data),
        .pop      (rx_pop),
        .head_dat (data_in),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    always_comb begin
        state_d   = state_q;
        tx_reg_d  = tx_reg_q;
        tx_busy_d = tx_busy_q;
        err_d     = err_q;

        case (state_q)
            IDLE:    if (!rx_empty) state_d = PEND;
            PEND:    if (cpu_rd_ack) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (cpu_rd_ack && (state_q != PEND)) begin
            err_d[ERR_RD_EMPTY] = 1'b1;
        end

        // Busy is judged on the pre-edge value, so a strobe coinciding with the handshake is rejected.
        if (tx_busy_q) begin
            if (cpu_wr_stb) err_d[ERR_WR_BUSY] = 1'b1;
            if (ext_out_ready) tx_busy_d = 1'b0;
        end else if (cpu_wr_stb) begin
            tx_reg_d  = data_out;
            tx_busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            tx_reg_q  <= '0;
            tx_busy_q <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            tx_reg_q  <= tx_reg_d;
            tx_busy_q <= tx_busy_d;
            err_q     <= err_d;
        end
    end

    assign ext_in_ready  = !rx_full;
    assign interrupt     = (state_q == PEND);
    assign tx_busy       = tx_busy_q;
    assign ext_out_valid = tx_busy_q;
    assign ext_out_data  = tx_reg_q;
    assign err_flags     = err_q;

endmodule

// File: tb/tb_mips_io_port.sv
// Directed and randomized checks of mips_io_port against a queue-based behavioural model.
module tb_mips_io_port;

    localparam int DATA_W   = 16;
    localparam int RX_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] ext_in_data;
    logic              ext_in_valid;
    logic              ext_in_ready;
    logic [DATA_W-1:0] data_in;
    logic              interrupt;
    logic              cpu_rd_ack;
    logic [DATA_W-1:0] data_out;
    logic              cpu_wr_stb;
    logic              tx_busy;
    logic [DATA_W-1:0] ext_out_data;
    logic              ext_out_valid;
    logic              ext_out_ready;
    logic [1:0]        err_flags;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: a word queue, an "interrupt up" flag with a low-time countdown,
    // a transmit slot and sticky error bits.
    logic [DATA_W-1:0] rxq[$];
    bit                m_irq;
    int                m_cool;
    logic [DATA_W-1:0] m_tx;
    bit                m_txb;
    logic [1:0]        m_err;

    mips_io_port #(.DATA_W(DATA_W), .RX_DEPTH(RX_DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .ext_in_data   (ext_in_data),
        .ext_in_valid  (ext_in_valid),
        .ext_in_ready  (ext_in_ready),
        .data_in       (data_in),
        .interrupt     (interrupt),
        .cpu_rd_ack    (cpu_rd_ack),
        .data_out      (data_out),
        .cpu_wr_stb    (cpu_wr_stb),
        .tx_busy       (tx_busy),
        .ext_out_data  (ext_out_data),
        .ext_out_valid (ext_out_valid),
        .ext_out_ready (ext_out_ready),
        .err_flags     (err_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        reset         = 1'b0;
        ext_in_data   = '0;
        ext_in_valid  = 1'b0;
        cpu_rd_ack    = 1'b0;
        data_out      = '0;
        cpu_wr_stb    = 1'b0;
        ext_out_ready = 1'b0;
    endtask

    // Check outputs against the model, advance the model by the current inputs, then clock once.
    task automatic cycle(input bit do_chk);
        bit had_word;
        bit can_push;
        if (do_chk) begin
            chk("m_data_in", 32'(data_in), (rxq.size() != 0) ? 32'(rxq[0]) : 32'h0);
            chk("m_ready", 32'(ext_in_ready), 32'(rxq.size() < RX_DEPTH));
            chk("m_irq", 32'(interrupt), 32'(m_irq));
            chk("m_tx_busy", 32'(tx_busy), 32'(m_txb));
            chk("m_out_valid", 32'(ext_out_valid), 32'(m_txb));
            chk("m_out_data", 32'(ext_out_data), 32'(m_tx));
            chk("m_err", 32'(err_flags), 32'(m_err));
        end
        if (reset) begin
            rxq.delete();
            m_irq  = 0;
            m_cool = 0;
            m_tx   = '0;
            m_txb  = 0;
            m_err  = '0;
        end else begin
            had_word = (rxq.size() != 0);
            can_push = (rxq.size() < RX_DEPTH);
            if (cpu_rd_ack && !m_irq) m_err[0] = 1'b1;
            if (m_irq) begin
                if (cpu_rd_ack) begin
                    void'(rxq.pop_front());
                    m_irq  = 0;
                    m_cool = 1;
                end
            end else if (m_cool > 0) begin
                m_cool--;
            end else begin
                m_irq = had_word;
            end
            if (ext_in_valid && can_push) rxq.push_back(ext_in_data);
            if (m_txb) begin
                if (cpu_wr_stb) m_err[1] = 1'b1;
                if (ext_out_ready) m_txb = 0;
            end else if (cpu_wr_stb) begin
                m_tx  = data_out;
                m_txb = 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_irq();
        int n = 0;
        while (!interrupt && n < 20) begin
            cycle(1);
            n++;
        end
        chk("irq_wait_timeout", 32'(interrupt), 32'h1);
    endtask

    task automatic pop_expect(input logic [DATA_W-1:0] w);
        wait_irq();
        chk("pop_head", 32'(data_in), 32'(w));
        cpu_rd_ack = 1'b1;
        cycle(1);
        cpu_rd_ack = 1'b0;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        ext_in_valid = 1'b1;
        ext_in_data  = w;
        cycle(1);
        ext_in_valid = 1'b0;
    endtask

    initial begin
        int gap;
        idle_inputs();

        // Reset
        reset = 1'b1;
        cycle(0);
        reset = 1'b0;
        chk("rst_irq", 32'(interrupt), 'h0);
        chk("rst_data_in", 32'(data_in), 'h0);
        chk("rst_ready", 32'(ext_in_ready), 'h1);
        chk("rst_tx_busy", 32'(tx_busy), 'h0);
        chk("rst_err", 32'(err_flags), 'h0);

        // Single word
        push_word(16'hA5A5);
        chk("single_head", 32'(data_in), 'hA5A5);
        chk("single_irq_n", 32'(interrupt), 'h0);
        cycle(1);
        chk("single_irq_n1", 32'(interrupt), 'h1);
        cpu_rd_ack = 1'b1;
        cycle(1);
        cpu_rd_ack = 1'b0;
        chk("single_gap0", 32'(interrupt), 'h0);
        chk("single_empty", 32'(data_in), 'h0);
        cycle(1);
        chk("single_gap1", 32'(interrupt), 'h0);

        // Fill and overflow attempt
        for (int i = 1; i <= 5; i++) begin
            ext_in_valid = 1'b1;
            ext_in_data  = DATA_W'(i);
            if (i == 5) chk("fill_ready_5th", 32'(ext_in_ready), 'h0);
            cycle(1);
        end
        ext_in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            pop_expect(DATA_W'(k));
            if (k < 4) begin
                gap = 0;
                while (!interrupt && gap < 10) begin
                    gap++;
                    cycle(1);
                end
                chk("fill_gap_len", 32'(gap), 'h2);
            end
        end
        repeat (3) cycle(1);

        // Simultaneous push/pop at count 2
        push_word(16'h0011);
        push_word(16'h0022);
        wait_irq();
        cpu_rd_ack   = 1'b1;
        ext_in_valid = 1'b1;
        ext_in_data  = 16'h0033;
        cycle(1);
        cpu_rd_ack   = 1'b0;
        ext_in_valid = 1'b0;
        chk("pp_head", 32'(data_in), 'h22);
        pop_expect(16'h0022);
        pop_expect(16'h0033);
        repeat (3) cycle(1);
        cpu_rd_ack = 1'b1;
        cycle(1);
        cpu_rd_ack = 1'b0;
        chk("rd_empty_err", 32'(err_flags), 'h1);
        chk("rd_empty_head", 32'(data_in), 'h0);

        // TX hold, dropped second strobe, handshake
        cpu_wr_stb = 1'b1;
        data_out   = 16'h1234;
        cycle(1);
        cpu_wr_stb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("tx_hold_valid", 32'(ext_out_valid), 'h1);
            chk("tx_hold_data", 32'(ext_out_data), 'h1234);
            cycle(1);
        end
        cpu_wr_stb = 1'b1;
        data_out   = 16'h5678;
        cycle(1);
        cpu_wr_stb = 1'b0;
        chk("tx_drop_data", 32'(ext_out_data), 'h1234);
        chk("tx_drop_err", 32'(err_flags[1]), 'h1);
        ext_out_ready = 1'b1;
        cycle(1);
        ext_out_ready = 1'b0;
        chk("tx_cleared", 32'(tx_busy), 'h0);

        // Reset mid-stream
        push_word(16'h0101);
        push_word(16'h0202);
        push_word(16'h0303);
        cpu_wr_stb = 1'b1;
        data_out   = 16'h0F0F;
        cycle(1);
        cpu_wr_stb = 1'b0;
        reset = 1'b1;
        cycle(1);
        reset = 1'b0;
        chk("mid_rst_head", 32'(data_in), 'h0);
        chk("mid_rst_irq", 32'(interrupt), 'h0);
        chk("mid_rst_ready", 32'(ext_in_ready), 'h1);
        chk("mid_rst_tx", 32'(tx_busy), 'h0);
        chk("mid_rst_out_data", 32'(ext_out_data), 'h0);
        chk("mid_rst_err", 32'(err_flags), 'h0);
        push_word(16'hBEEF);
        chk("post_rst_head", 32'(data_in), 'hBEEF);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(199) == 0);
            ext_in_valid  = ($urandom_range(1) == 1);
            ext_in_data   = DATA_W'($urandom);
            cpu_rd_ack    = ($urandom_range(2) == 0);
            cpu_wr_stb    = ($urandom_range(2) == 0);
            data_out      = DATA_W'($urandom);
            ext_out_ready = ($urandom_range(1) == 1);
            cycle(1);
        end
        idle_inputs();
        cycle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
